// File: rtl/qtcore_scan_pkg.sv
// Shared state encoding and widths for the qtcore scan-chain loader.
package qtcore_scan_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } scan_state_t;

   localparam int BYTE_W    = 8;
   localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/qtcore_scan_shifter.sv
// Byte serialiser/deserialiser: PISO drives the chain MSB-first, SIPO collects what falls out.
// Latency: load visible on ser_out next cycle; par_out holds the complete byte during the last shift cycle.
// Backpressure: none; the caller only shifts while a byte is loaded.
module qtcore_scan_shifter
   import qtcore_scan_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [BYTE_W-1:0] load_data,
   input  logic              shift,
   output logic              ser_out,
   input  logic              ser_in,
   output logic [BYTE_W-1:0] par_out,
   output logic              last_bit
);

   logic [BYTE_W-1:0]    r_piso;
   logic [BYTE_W-2:0]    r_sipo;
   logic [BIT_CNT_W-1:0] r_bit_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_piso    <= '0;
         r_sipo    <= '0;
         r_bit_cnt <= '0;
      end else begin
         if (load)
            r_piso <= load_data;
         else if (shift)
            r_piso <= {r_piso[BYTE_W-2:0], 1'b0};
         if (shift)
            r_sipo <= {r_sipo[BYTE_W-3:0], ser_in};
         if (load)
            r_bit_cnt <= '0;
         else if (shift)
            r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // Only seven bits are stored; the eighth comes straight from ser_in so the
   // whole byte is ready on the final shift cycle.
   assign par_out  = {r_sipo, ser_in};
   assign ser_out  = r_piso[BYTE_W-1];
   assign last_bit = (r_bit_cnt == '1);

endmodule

// File: rtl/qtcore_scan_loader.sv
// Host byte stream -> core scan chain loader with readback and proc_en arbitration (option: SCAN_AUTORUN_EN).
// Latency: byte accepted at edge N shifts in the next 8 cycles; readback strobe 1 cycle after the 8th shift.
// Backpressure: wr_ready only when no byte is loaded or the loaded byte is on its last bit; rd has none.
module qtcore_scan_loader
   import qtcore_scan_pkg::*;
#(
   parameter int SCAN_BYTES = 15
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       scan_enable,
   output logic       scan_in,
   input  logic       scan_out,
   input  logic       proc_req,
   output logic       proc_en,
   output logic       busy,
   output logic       done
);

   localparam int                BCNT_W    = $clog2(SCAN_BYTES + 1);
   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(SCAN_BYTES);

   scan_state_t       r_state;
   logic              r_loaded;
   logic [BCNT_W-1:0] r_byte_cnt;
   logic              r_rd_valid;
   logic [7:0]        r_rd_data;
   logic              r_proc_en;

   logic              w_last_bit;
   logic              w_byte_end;
   logic              w_final;
   logic              w_accept;
   logic              w_ser_out;
   logic [7:0]        w_par;

   assign w_byte_end = r_loaded && w_last_bit;
   assign w_final    = w_byte_end && (r_byte_cnt == LAST_BYTE);
   assign wr_ready   = (r_state == S_SHIFT) &&
                       (!r_loaded || (w_last_bit && (r_byte_cnt != LAST_BYTE)));
   assign w_accept   = wr_valid && wr_ready;

   qtcore_scan_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (w_accept),
      .load_data (wr_data),
      .shift     (r_loaded),
      .ser_out   (w_ser_out),
      .ser_in    (scan_out),
      .par_out   (w_par),
      .last_bit  (w_last_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_loaded   <= 1'b0;
         r_byte_cnt <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_proc_en  <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_SHIFT;
                  r_byte_cnt <= '0;
                  r_loaded   <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (w_accept) begin
                  r_loaded   <= 1'b1;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end else if (w_byte_end) begin
                  r_loaded   <= 1'b0;
               end
               if (w_final)
                  r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_byte_end) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= w_par;
         end

         // Dropped on the same edge SHIFT is entered, so it never overlaps scan_enable.
         if (r_state == S_SHIFT || start)
            r_proc_en <= 1'b0;
`ifdef SCAN_AUTORUN_EN
         else if (r_state == S_DONE)
            r_proc_en <= 1'b1;
`endif
         else
            r_proc_en <= proc_req;
      end
   end

   assign scan_enable = r_loaded;
   assign scan_in     = w_ser_out;
   assign rd_valid    = r_rd_valid;
   assign rd_data     = r_rd_data;
   assign proc_en     = r_proc_en;
   assign busy        = (r_state == S_SHIFT);
   assign done        = (r_state == S_DONE);

endmodule
